vga_timing_ctrl: RTL
====================

Name: vga_timing_ctrl

Overview:
Sequences the DE10-Lite VGA output path. Generates horizontal/vertical counters, sync and blanking, and issues per-pixel fetch requests to a pixel source with fixed read latency. Aligns the returned RGB with delayed sync so the vdbVGAMonitor sees a coherent stream. Sits between the design's frame/pattern source and the VGA_R/G/B/HS/VS pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
HS_POL, 0, hsync active level (0 = active low)
VS_POL, 0, vsync active level
RD_LATENCY, 2, cycles from pix_req to pix_valid/pix_rgb; legal 1..4

Ports:
pixel_clk  in  1  pixel clock, all logic rising-edge
rst  in  1  asynchronous reset, active high
enable  in  1  run request
pix_req  out  1  fetch pixel at pix_x/pix_y this cycle
pix_x  out  10  requested column
pix_y  out  10  requested row
pix_valid  in  1  source data valid, RD_LATENCY after pix_req
pix_rgb  in  12  {r[3:0],g[3:0],b[3:0]} from source
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
vga_hsync  out  1  hsync, polarity per HS_POL
vga_vsync  out  1  vsync, polarity per VS_POL
frame_start  out  1  one-cycle pulse aligned with first active pixel on vga_*
busy  out  1  state != IDLE
underrun  out  1  sticky: active pixel slot had pix_valid low
underrun_clr  in  1  clears underrun

Behaviour:
- Reset: state IDLE, hcnt=vcnt=0, pix_req=0, pix_x=pix_y=0, vga_r/g/b=0, vga_hsync=~HS_POL, vga_vsync=~VS_POL, frame_start=0, busy=0, underrun=0; delay-line stages reset to inactive.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL likewise (525); both must be <=1024 (10-bit counters).
- hcnt increments every RUN/DRAIN cycle; wraps H_TOTAL-1 -> 0 and advances vcnt; vcnt wraps V_TOTAL-1 -> 0.
- Counter stage: active = hcnt<H_ACTIVE && vcnt<V_ACTIVE; hs = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- pix_req=active, pix_x=hcnt, pix_y=vcnt combinationally from counter registers; pix_x/pix_y hold last value when pix_req=0.
- active, hs, vs, sof (hcnt=0 && vcnt=0) delayed RD_LATENCY cycles, then registered onto outputs with rgb: pixel requested at cycle t appears on vga_* at t+RD_LATENCY+1.
- Output stage: delayed-active && pix_valid -> vga_rgb=pix_rgb; otherwise 0. delayed-active && !pix_valid -> underrun set. pix_valid outside active slot ignored.
- underrun: set and underrun_clr in same cycle -> set wins.
- FSM IDLE: counters held 0, no req, syncs inactive. enable=1 -> RUN; first counter-stage cycle (0,0) is the next cycle.
- RUN: enable=0 -> DRAIN (counting continues, reqs continue).
- DRAIN: enable=1 -> RUN, no timing disturbance. At hcnt=H_TOTAL-1 && vcnt=V_TOTAL-1 with enable=0 -> IDLE; in-flight delay-line contents flush normally (syncs return inactive, rgb 0).
- frame_start pulses only for sof generated in RUN/DRAIN.
- Reset mid-frame: immediate return to reset values; no partial pulse.

Test Plan:
- Reset then enable=1, source always valid: hsync low for exactly 96 cycles every 800; vsync low for 2 lines (1600 cycles) every 525 lines; frame period 420000 cycles.
- Request/latency: pix_rgb=12'hA5C returned with pix_valid at RD_LATENCY=2 for (0,0) -> vga_r=A,g=5,b=C exactly 3 cycles after pix_req, coincident with frame_start.
- Blanking: pix_rgb=12'hFFF with pix_valid forced 1 always -> vga_rgb=0 at hcnt 640..799 and lines 480..524.
- Underrun: drop pix_valid for pixel (100,20) -> that output pixel 0, underrun=1 and sticky; underrun_clr same cycle as new drop -> stays 1; clr alone -> 0.
- enable=0 mid-frame at line 200 -> frame completes, busy falls after last cycle of line 524, outputs inactive; re-enable during DRAIN at line 300 -> no gap, next frame_start exactly 420000 cycles after previous.
- Async rst asserted at (hcnt=350,vcnt=100) -> all outputs at reset values within the same cycle, pix_req=0.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: counters, sync/blank, pixel fetch requests,
// and a delay line that realigns returned RGB with the syncs.
module vga_timing_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int RD_LATENCY = 2
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        enable,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  input  logic        pix_valid,
  input  logic [11:0] pix_rgb,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start,
  output logic        busy,
  output logic        underrun,
  input  logic        underrun_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] HL  = 10'(H_TOTAL - 1);
  localparam logic [9:0] VL  = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [9:0]  x_hold;
  logic [9:0]  y_hold;
  logic        run;
  logic        h_last;
  logic        v_last;
  logic        act_c;
  logic        hs_c;
  logic        vs_c;
  logic        sof_c;
  logic [3:0]  dl [RD_LATENCY];
  logic        d_act;
  logic        d_hs;
  logic        d_vs;
  logic        d_sof;
  logic [11:0] rgb_q;

  assign run    = (state != IDLE);
  assign busy   = run;
  assign h_last = (hcnt == HL);
  assign v_last = (vcnt == VL);

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enable) state_nx = RUN;
      RUN:     if (!enable) state_nx = DRAIN;
      DRAIN: begin
        if (enable)               state_nx = RUN;
        else if (h_last && v_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (run) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Counter-stage flags are gated by run so IDLE's held (0,0) is silent.
  assign act_c = run && (hcnt < HA) && (vcnt < VA);
  assign hs_c  = run && (hcnt >= HS0) && (hcnt < HS1);
  assign vs_c  = run && (vcnt >= VS0) && (vcnt < VS1);
  assign sof_c = run && (hcnt == '0) && (vcnt == '0);

  assign pix_req = act_c;
  assign pix_x   = act_c ? hcnt : x_hold;
  assign pix_y   = act_c ? vcnt : y_hold;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      x_hold <= '0;
      y_hold <= '0;
    end else if (act_c) begin
      x_hold <= hcnt;
      y_hold <= vcnt;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) dl[i] <= '0;
    end else begin
      dl[0] <= {act_c, hs_c, vs_c, sof_c};
      for (int i = 1; i < RD_LATENCY; i++) dl[i] <= dl[i-1];
    end
  end

  assign {d_act, d_hs, d_vs, d_sof} = dl[RD_LATENCY-1];

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      rgb_q       <= '0;
      vga_hsync   <= ~HS_POL;
      vga_vsync   <= ~VS_POL;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      rgb_q       <= (d_act && pix_valid) ? pix_rgb : '0;
      vga_hsync   <= d_hs ? HS_POL : ~HS_POL;
      vga_vsync   <= d_vs ? VS_POL : ~VS_POL;
      frame_start <= d_sof;
      if (d_act && !pix_valid) underrun <= 1'b1;
      else if (underrun_clr)   underrun <= 1'b0;
    end
  end

  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];

endmodule
